// File: rtl/fwrdk2j_ctrl_pkg.sv
// fwrdk2j_ctrl_pkg: shared state encoding and default widths for the
// fwrdk2j kernel sequencer and its settle timer.
package fwrdk2j_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;
    localparam int TMR_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        SETTLE,
        OUTPUT,
        DONE
    } state_t;

endpackage

// File: rtl/fwrdk2j_settle_timer.sv
// fwrdk2j_settle_timer: counts cycles after a load; o_expire flags the
// last cycle of the settle window while enabled.
module fwrdk2j_settle_timer
    import fwrdk2j_ctrl_pkg::*;
#(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [TMR_W-1:0] r_cnt;

    // Load to 1 so the count equals the settle cycle currently in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= TMR_W'(1);
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == TMR_W'(LIMIT));

endmodule

// File: rtl/fwrdk2j_seq_ctrl.sv
// fwrdk2j_seq_ctrl: batch sequencer for the combinational fwrdk2j kernel.
// Optional results-delivered counter enabled by FWRDK2J_TXN_CNT_EN.
module fwrdk2j_seq_ctrl
    import fwrdk2j_ctrl_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    cfg_count,
    output logic                busy,
    output logic                done,
`ifdef FWRDK2J_TXN_CNT_EN
    output logic [CNT_W-1:0]    txn_count,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    output logic [DATA_W-1:0]   k_in0,
    output logic [DATA_W-1:0]   k_in1,
    input  logic [DATA_W-1:0]   k_out0,
    input  logic [DATA_W-1:0]   k_out1,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2*DATA_W-1:0] res_data
);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_rem;
    logic [DATA_W-1:0]   r_k_in0;
    logic [DATA_W-1:0]   r_k_in1;
    logic [2*DATA_W-1:0] r_res_data;
    logic                r_res_valid;
    logic                w_in_hs;
    logic                w_res_hs;
    logic                w_expire;
    logic                w_settle;

    assign w_in_hs  = in_valid && in_ready;
    assign w_res_hs = r_res_valid && res_ready;
    assign w_settle = (r_state == SETTLE);

    fwrdk2j_settle_timer #(
        .LIMIT    (SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_in_hs),
        .i_en     (w_settle),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (cfg_count == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                if (w_in_hs) begin
                    w_next = SETTLE;
                end
            end
            SETTLE: begin
                if (w_expire) begin
                    w_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (w_res_hs) begin
                    w_next = (r_rem != '0) ? ACCEPT : DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Kernel inputs only move on a handshake so the kernel never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_k_in0 <= '0;
            r_k_in1 <= '0;
        end else if (r_state == IDLE && start) begin
            r_rem <= cfg_count;
        end else if (w_in_hs) begin
            r_rem   <= r_rem - 1'b1;
            r_k_in0 <= in_a;
            r_k_in1 <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_expire) begin
            r_res_valid <= 1'b1;
            r_res_data  <= {k_out1, k_out0};
        end else if (w_res_hs) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef FWRDK2J_TXN_CNT_EN
    logic [CNT_W-1:0] r_txn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn <= '0;
        end else if (w_res_hs) begin
            r_txn <= r_txn + 1'b1;
        end
    end

    assign txn_count = r_txn;
`endif

    assign in_ready  = (r_state == ACCEPT);
    assign busy      = (r_state == ACCEPT) || (r_state == SETTLE)
                    || (r_state == OUTPUT);
    assign done      = (r_state == DONE);
    assign k_in0     = r_k_in0;
    assign k_in1     = r_k_in1;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_fwrdk2j_seq_ctrl.sv
// Self-checking bench for fwrdk2j_seq_ctrl with a simple add/xor kernel model.
// Covers the FWRDK2J_TXN_CNT_EN counter when that macro is defined.
module tb_fwrdk2j_seq_ctrl;

    localparam int DW = 32;
    localparam int ST = 2;
`ifdef FWRDK2J_TXN_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_count = '0;
    logic          busy;
    logic          done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [DW-1:0] k_in0;
    logic [DW-1:0] k_in1;
    logic [DW-1:0] k_out0;
    logic [DW-1:0] k_out1;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [2*DW-1:0] res_data;
`ifdef FWRDK2J_TXN_CNT_EN
    logic [CW-1:0] txn_count;
`endif

    logic [2*DW-1:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    assign k_out0 = k_in0 + k_in1;
    assign k_out1 = k_in0 ^ k_in1;

    always #5 clk = ~clk;

    fwrdk2j_seq_ctrl #(
        .DATA_W        (DW),
        .SETTLE_CYCLES (ST),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_count (cfg_count),
        .busy      (busy),
        .done      (done),
`ifdef FWRDK2J_TXN_CNT_EN
        .txn_count (txn_count),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .k_in0     (k_in0),
        .k_in1     (k_in1),
        .k_out0    (k_out0),
        .k_out1    (k_out1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if ({busy, done, in_ready, res_valid} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {busy, done, in_ready, res_valid});
        end
        n_vec++;
        if (k_in0 !== '0 || k_in1 !== '0 || res_data !== '0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%h/%h exp=0",
                     k_in0, k_in1, res_data);
        end
`ifdef FWRDK2J_TXN_CNT_EN
        n_vec++;
        if (txn_count !== '0) begin
            n_err++;
            $display("FAIL reset_txn got=%0d exp=0", txn_count);
        end
`endif
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset got=%b%b exp=00", busy, in_ready);
        end
    endtask

    task automatic test_batch();
        logic [DW-1:0]   va [3];
        logic [DW-1:0]   vb [3];
        logic [2*DW-1:0] e;
        int sent  = 0;
        int got   = 0;
        int dones = 0;
        int hs_at = 0;
        int cyc   = 0;
        va = '{32'd1, 32'd3, 32'd5};
        vb = '{32'd2, 32'd4, 32'd6};
        res_ready = 1'b1;
        cfg_count = CW'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL batch_start got=%b%b exp=11", busy, in_ready);
        end
        in_valid = 1'b1;
        in_a = va[0];
        in_b = vb[0];
        while (dones == 0 && cyc < 200) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({va[sent] ^ vb[sent], va[sent] + vb[sent]});
                hs_at = cyc + 1;
                sent++;
            end
            if (res_valid && res_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_vec++;
                if (res_data !== e) begin
                    n_err++;
                    $display("FAIL batch_data got=%h exp=%h", res_data, e);
                end
                n_vec++;
                if (cyc != hs_at + ST) begin
                    n_err++;
                    $display("FAIL batch_latency got=%0d exp=%0d",
                             cyc - hs_at, ST);
                end
                n_vec++;
                if (k_in0 !== va[got] || k_in1 !== vb[got]) begin
                    n_err++;
                    $display("FAIL k_in_hold got=%h/%h exp=%h/%h",
                             k_in0, k_in1, va[got], vb[got]);
                end
                got++;
            end
            if (done) begin
                dones++;
                n_vec++;
                if (got != 3 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL batch_done got=%0d busy=%b exp=3 busy=0",
                             got, busy);
                end
            end
            tick();
            cyc++;
            if (sent < 3) begin
                in_a = va[sent];
                in_b = vb[sent];
            end else begin
                in_valid = 1'b0;
            end
        end
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL batch_timeout got=%0d exp=1 done", dones);
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL batch_end got=%b%b exp=00", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        cfg_count = CW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 32'd7;
        in_b = 32'd9;
        tick();
        in_valid = 1'b0;
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, in_ready, res_valid} !== 4'b0 || k_in0 !== '0 ||
            k_in1 !== '0 || res_data !== '0) begin
            n_err++;
            $display("FAIL reset_mid got=%b %h %h %h exp=0",
                     {busy, done, in_ready, res_valid}, k_in0, k_in1, res_data);
        end
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            if (done || busy || res_valid) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_mid_after got=%0d bad cycles exp=0", bad);
        end
    endtask

    task automatic test_zero();
        int bad = 0;
        cfg_count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done got=%b%b%b exp=100", done, busy, in_ready);
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_pulse got=%b exp=0", done);
        end
        repeat (5) begin
            tick();
            if (in_ready || res_valid || done) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL zero_quiet got=%0d bad cycles exp=0", bad);
        end
    endtask

    task automatic test_backpressure();
        logic [2*DW-1:0] e;
        logic [2*DW-1:0] hold;
        int bad = 0;
        int w   = 0;
        res_ready = 1'b0;
        cfg_count = CW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 32'h1234_5678;
        in_b = 32'h0f0f_0f0f;
        if (in_ready) exp_q.push_back({in_a ^ in_b, in_a + in_b});
        tick();
        in_valid = 1'b0;
        while (!res_valid && w < 20) begin
            tick();
            w++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            n_err++;
            $display("FAIL bp_data got=%b %h exp=1 %h", res_valid, res_data, e);
        end
        hold = res_data;
        repeat (10) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== hold || in_ready !== 1'b0)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_stable got=%0d bad cycles exp=0", bad);
        end
        res_ready = 1'b1;
        tick();
        n_vec++;
        if (res_valid !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got=%b%b exp=01", res_valid, done);
        end
        tick();
    endtask

    task automatic test_busy_start();
        logic [2*DW-1:0] e;
        int got   = 0;
        int dones = 0;
        int cyc   = 0;
        int bad   = 0;
        logic [DW-1:0] a;
        cfg_count = CW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_count = CW'(7);
        in_valid = 1'b1;
        a = 32'h100;
        in_a = a;
        in_b = 32'h55;
        while (dones == 0 && cyc < 200) begin
            start = busy;
            if (in_valid && in_ready) exp_q.push_back({in_a ^ in_b, in_a + in_b});
            if (res_valid && res_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_vec++;
                if (res_data !== e) begin
                    n_err++;
                    $display("FAIL busy_data got=%h exp=%h", res_data, e);
                end
                got++;
            end
            if (done) dones++;
            tick();
            cyc++;
            if (in_ready) begin
                a = a + 32'h11;
                in_a = a;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        repeat (4) begin
            tick();
            if (busy || res_valid || done) bad++;
        end
        n_vec++;
        if (got != 2 || dones != 1 || bad != 0) begin
            n_err++;
            $display("FAIL busy_start got=%0d res %0d done %0d bad exp=2 1 0",
                     got, dones, bad);
        end
    endtask

`ifdef FWRDK2J_TXN_CNT_EN
    task automatic test_txn_count();
        int sizes [2];
        int cyc;
        sizes = '{15, 2};
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        res_ready = 1'b1;
        foreach (sizes[i]) begin
            cfg_count = CW'(sizes[i]);
            start = 1'b1;
            tick();
            start = 1'b0;
            in_valid = 1'b1;
            in_a = 32'd3 + 32'(i);
            cyc = 0;
            while (!done && cyc < 400) begin
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            tick();
        end
        n_vec++;
        if (txn_count !== CW'(1)) begin
            n_err++;
            $display("FAIL txn_wrap got=%0d exp=1", txn_count);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (txn_count !== '0) begin
            n_err++;
            $display("FAIL txn_reset got=%0d exp=0", txn_count);
        end
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_batch();
        test_reset_mid();
        test_zero();
        test_backpressure();
        test_busy_start();
`ifdef FWRDK2J_TXN_CNT_EN
        test_txn_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
